// File: rtl/pipeline_stage_ctrl_pkg.sv
// Shared encodings for the pipeline controller:
// memory status codes and MEM handshake states.
package pipeline_stage_ctrl_pkg;

  localparam logic [1:0] MEM_IDLE = 2'b00;
  localparam logic [1:0] MEM_BUSY = 2'b01;
  localparam logic [1:0] MEM_DONE = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_HOLD = 2'b10
  } mem_st_e;

endpackage

// File: rtl/pipeline_stage_ctrl_if.sv
// Core-side bundle of the pipeline controller:
// per-stage status in, latch enables and PC/mem strobes out.
interface pipeline_stage_ctrl_if #(
  parameter int STAGE_NUM = 5,
  parameter int CNT_WIDTH = 32
) ();

  logic                 if_inst_valid;
  logic [STAGE_NUM-1:0] stage_busy;
  logic                 id_hazard;
  logic                 redirect_valid;
  logic                 mem_req;
  logic [1:0]           mem_vis_status;

  logic [STAGE_NUM-1:0] stage_valid;
  logic [STAGE_NUM-1:0] stage_fire;
  logic                 inst_fetch_enabled;
  logic                 pc_update_en;
  logic                 pc_redirect_en;
  logic                 mem_vis_enabled;
  logic [CNT_WIDTH-1:0] stall_cycle_cnt;

  modport master (
    input  if_inst_valid,
    input  stage_busy,
    input  id_hazard,
    input  redirect_valid,
    input  mem_req,
    input  mem_vis_status,
    output stage_valid,
    output stage_fire,
    output inst_fetch_enabled,
    output pc_update_en,
    output pc_redirect_en,
    output mem_vis_enabled,
    output stall_cycle_cnt
  );

  modport slave (
    output if_inst_valid,
    output stage_busy,
    output id_hazard,
    output redirect_valid,
    output mem_req,
    output mem_vis_status,
    input  stage_valid,
    input  stage_fire,
    input  inst_fetch_enabled,
    input  pc_update_en,
    input  pc_redirect_en,
    input  mem_vis_enabled,
    input  stall_cycle_cnt
  );

endinterface

// File: rtl/pipeline_stage_ctrl_mem_access_fsm.sv
// MEM-stage access handshake: one request pulse,
// wait for done, park in HOLD while downstream is blocked.
module mem_access_fsm
  import pipeline_stage_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy_in_i,
  input  logic       active_i,
  input  logic [1:0] status_i,
  input  logic       ds_stall_i,
  input  logic       fire_i,
  output logic       mem_hold_o,
  output logic       mem_vis_enabled_o
);

  mem_st_e state_q, state_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else if (rdy_in_i) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (active_i) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (status_i == MEM_DONE) begin
          if (fire_i && !ds_stall_i) state_d = ST_IDLE;
          else                       state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (fire_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_hold_o        = 1'b0;
    mem_vis_enabled_o = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        mem_hold_o        = active_i;
        mem_vis_enabled_o = active_i & rdy_in_i;
      end
      ST_WAIT: begin
        // reserved status 2'b11 waits like busy
        unique case (status_i)
          MEM_DONE:           mem_hold_o = 1'b0;
          MEM_IDLE, MEM_BUSY: mem_hold_o = 1'b1;
          default:            mem_hold_o = 1'b1;
        endcase
      end
      ST_HOLD: mem_hold_o = 1'b0;
      default: mem_hold_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/pipeline_stage_ctrl.sv
// N-stage valid/stall/fire controller with load-use bubbles,
// branch flush and the MEM access handshake.
module pipeline_stage_ctrl
  import pipeline_stage_ctrl_pkg::*;
#(
  parameter int STAGE_NUM = 5,
  parameter int ID_STAGE  = 1,
  parameter int EXE_STAGE = 2,
  parameter int MEM_STAGE = 3,
  parameter int CNT_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy_in,
  pipeline_stage_ctrl_if.master bus
);

  logic [STAGE_NUM-1:1] valid_q, valid_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [STAGE_NUM-1:0] v;
  logic [STAGE_NUM:0]   chain;
  logic [STAGE_NUM-1:0] stall;
  logic [STAGE_NUM-1:0] fire;
  logic                 redir;
  logic                 mem_hold;
  logic                 mem_vis;
  logic                 mem_active;

  // the stall chain runs from WB toward IF
  always_comb begin
    v = '0;
    if (!rst) v = {valid_q, bus.if_inst_valid};
    chain = '0;
    for (int i = STAGE_NUM - 1; i >= 0; i--) begin
      chain[i] = v[i] & (bus.stage_busy[i] | chain[i+1]
               | ((i == MEM_STAGE) && mem_hold)
               | ((i == ID_STAGE) && bus.id_hazard));
    end
    stall = chain[STAGE_NUM-1:0];
    fire  = v & ~stall & {STAGE_NUM{rdy_in}};
  end

  assign mem_active = v[MEM_STAGE] & bus.mem_req;

  mem_access_fsm u_mem_fsm (
    .clk               (clk),
    .rst               (rst),
    .rdy_in_i          (rdy_in),
    .active_i          (mem_active),
    .status_i          (bus.mem_vis_status),
    .ds_stall_i        (chain[MEM_STAGE+1]),
    .fire_i            (fire[MEM_STAGE]),
    .mem_hold_o        (mem_hold),
    .mem_vis_enabled_o (mem_vis)
  );

  assign redir = bus.redirect_valid & fire[EXE_STAGE];

  // a flush beats any stall in the front stages
  always_comb begin
    valid_d = valid_q;
    for (int i = 1; i < STAGE_NUM; i++) begin
      if (redir && (i <= EXE_STAGE)) valid_d[i] = 1'b0;
      else if (stall[i])             valid_d[i] = valid_q[i];
      else                           valid_d[i] = fire[i-1];
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall[0]) cnt_d = cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      cnt_q   <= '0;
    end else if (rdy_in) begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.stage_valid        = v;
  assign bus.stage_fire         = fire;
  assign bus.pc_redirect_en     = redir;
  assign bus.pc_update_en       = fire[0] & ~redir;
  assign bus.inst_fetch_enabled = rdy_in & ~rst & ~stall[1];
  assign bus.mem_vis_enabled    = mem_vis;
  assign bus.stall_cycle_cnt    = rst ? '0 : cnt_q;

endmodule

// File: tb/tb_pipeline_stage_ctrl.sv
// Bench for pipeline_stage_ctrl: directed scenarios with literal
// expectations plus random traffic against an instruction-level model.
module tb_pipeline_stage_ctrl;
  import pipeline_stage_ctrl_pkg::*;

  localparam int S   = 5;
  localparam int CW  = 32;
  localparam int IDS = 1;
  localparam int EXS = 2;
  localparam int MES = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rdy_in = 1'b1;

  pipeline_stage_ctrl_if #(.STAGE_NUM(S), .CNT_WIDTH(CW)) bus ();

  pipeline_stage_ctrl #(
    .STAGE_NUM(S), .ID_STAGE(IDS), .EXE_STAGE(EXS),
    .MEM_STAGE(MES), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in), .bus(bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // model: instruction occupancy per stage plus the MEM
  // occupant's access progress (requested / completed)
  bit [S-1:1]    m_v, n_v;
  bit            m_iss, m_cmp, n_iss, n_cmp;
  logic [CW-1:0] m_cnt = '0, n_cnt = '0;
  bit [S-1:0]    e_v, e_st, e_fi;
  bit            e_hold, e_vis, e_redir, e_ife, e_pcu, down;
  logic [45:0]   e_b, a_b;

  always @(negedge clk) begin
    e_v = rst ? '0 : {m_v, bus.if_inst_valid};
    e_hold = 1'b0;
    e_vis  = 1'b0;
    if (m_iss && !m_cmp) begin
      e_hold = (bus.mem_vis_status != MEM_DONE);
    end else if (!m_iss && e_v[MES] && bus.mem_req) begin
      e_hold = 1'b1;
      e_vis  = rdy_in;
    end
    down = 1'b0;
    for (int i = S - 1; i >= 0; i--) begin
      e_st[i] = e_v[i] & (bus.stage_busy[i] | down
              | ((i == MES) && e_hold)
              | ((i == IDS) && bus.id_hazard));
      down = e_st[i];
    end
    e_fi    = rdy_in ? (e_v & ~e_st) : '0;
    e_redir = bus.redirect_valid & e_fi[EXS];
    e_ife   = rdy_in & !rst & !e_st[1];
    e_pcu   = e_fi[0] & !e_redir;
    e_b = {e_v, e_fi, e_ife, e_pcu, e_redir, e_vis,
           (rst ? {CW{1'b0}} : m_cnt)};
    a_b = {bus.stage_valid, bus.stage_fire, bus.inst_fetch_enabled,
           bus.pc_update_en, bus.pc_redirect_en, bus.mem_vis_enabled,
           bus.stall_cycle_cnt};
    checks++;
    if (a_b !== e_b) begin
      errors++;
      $display("FAIL cycle_model t=%0t got v=%b f=%b ife=%b pcu=%b pcr=%b vis=%b cnt=%0d expected v=%b f=%b ife=%b pcu=%b pcr=%b vis=%b cnt=%0d",
        $time, a_b[45:41], a_b[40:36], a_b[35], a_b[34], a_b[33], a_b[32], a_b[31:0],
        e_b[45:41], e_b[40:36], e_b[35], e_b[34], e_b[33], e_b[32], e_b[31:0]);
    end
    n_v = m_v; n_iss = m_iss; n_cmp = m_cmp; n_cnt = m_cnt;
    if (rst) begin
      n_v = '0; n_iss = 1'b0; n_cmp = 1'b0; n_cnt = '0;
    end else if (rdy_in) begin
      for (int i = 1; i < S; i++) begin
        if (e_redir && i <= EXS) n_v[i] = 1'b0;
        else if (e_st[i])        n_v[i] = m_v[i];
        else                     n_v[i] = e_fi[i-1];
      end
      if (e_fi[MES]) begin
        n_iss = 1'b0; n_cmp = 1'b0;
      end else if (e_vis) begin
        n_iss = 1'b1;
      end else if (m_iss && !m_cmp && bus.mem_vis_status == MEM_DONE) begin
        n_cmp = 1'b1;
      end
      if (e_st[0]) n_cnt = m_cnt + 1;
    end
  end

  always @(posedge clk) begin
    m_v   <= n_v;
    m_iss <= n_iss;
    m_cmp <= n_cmp;
    m_cnt <= n_cnt;
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic ifv, input logic [S-1:0] busy,
                       input logic hz, input logic rv, input logic mr,
                       input logic [1:0] st);
    rst = r;
    bus.if_inst_valid  = ifv;
    bus.stage_busy     = busy;
    bus.id_hazard      = hz;
    bus.redirect_valid = rv;
    bus.mem_req        = mr;
    bus.mem_vis_status = st;
  endtask

  int pcu_n, vis_n, mstall;

  initial begin
    rdy_in = 1'b1;
    drive(1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b0, MEM_IDLE);
    nxt();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("rst_valid", 64'(bus.stage_valid), 64'd0);
      chk("rst_cnt", 64'(bus.stall_cycle_cnt), 64'd0);
      chk("rst_pcu", 64'(bus.pc_update_en), 64'd0);
      nxt();
    end
    // steady flow
    drive(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0, MEM_IDLE);
    pcu_n = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      pcu_n += int'(bus.pc_update_en);
      if (c == 4) chk("fill_valid", 64'(bus.stage_valid), 64'h1f);
      nxt();
    end
    chk("steady_pcu", 64'(pcu_n), 64'd6);
    chk("steady_cnt", 64'(bus.stall_cycle_cnt), 64'd0);
    // load-use
    bus.id_hazard = 1'b1;
    @(negedge clk);
    chk("haz_ife", 64'(bus.inst_fetch_enabled), 64'd0);
    chk("haz_fire1", 64'(bus.stage_fire[1]), 64'd0);
    nxt();
    bus.id_hazard = 1'b0;
    @(negedge clk);
    chk("haz_bubble", 64'(bus.stage_valid[2]), 64'd0);
    chk("haz_hold1", 64'(bus.stage_valid[1]), 64'd1);
    chk("haz_cnt", 64'(bus.stall_cycle_cnt), 64'd1);
    nxt();
    // branch redirect
    bus.redirect_valid = 1'b1;
    @(negedge clk);
    chk("br_pre_valid", 64'(bus.stage_valid), 64'h17);
    chk("br_pcr", 64'(bus.pc_redirect_en), 64'd1);
    chk("br_pcu", 64'(bus.pc_update_en), 64'd0);
    nxt();
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("br_flush", 64'(bus.stage_valid[3:1]), 64'h4);
    nxt();
    bus.if_inst_valid = 1'b0;
    for (int c = 0; c < 6; c++) nxt();
    // memory access
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0, MEM_IDLE);
    nxt();
    drive(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b1, MEM_BUSY);
    vis_n = 0;
    mstall = 0;
    for (int r = 0; r < 8; r++) begin
      if (r == 7) bus.mem_vis_status = MEM_DONE;
      @(negedge clk);
      vis_n += int'(bus.mem_vis_enabled);
      mstall += int'(bus.stage_valid[MES] & ~bus.stage_fire[MES]);
      if (r == 7) begin
        chk("mem_fire", 64'(bus.stage_fire[MES]), 64'd1);
        chk("mem_cnt", 64'(bus.stall_cycle_cnt), 64'd4);
      end
      nxt();
    end
    chk("mem_pulse", 64'(vis_n), 64'd1);
    chk("mem_stall", 64'(mstall), 64'd4);
    // done under backpressure
    drive(1'b0, 1'b1, 5'b10000, 1'b0, 1'b0, 1'b1, MEM_BUSY);
    @(negedge clk);
    chk("bp_req", 64'(bus.mem_vis_enabled), 64'd1);
    nxt();
    nxt();
    bus.mem_vis_status = MEM_DONE;
    @(negedge clk);
    chk("bp_done_nofire", 64'(bus.stage_fire[MES]), 64'd0);
    chk("bp_done_novis", 64'(bus.mem_vis_enabled), 64'd0);
    nxt();
    bus.mem_vis_status = MEM_IDLE;
    @(negedge clk);
    chk("bp_hold_nofire", 64'(bus.stage_fire[MES]), 64'd0);
    chk("bp_hold_novis", 64'(bus.mem_vis_enabled), 64'd0);
    nxt();
    bus.stage_busy = '0;
    @(negedge clk);
    chk("bp_release_fire", 64'(bus.stage_fire[MES]), 64'd1);
    chk("bp_release_novis", 64'(bus.mem_vis_enabled), 64'd0);
    nxt();
    // freeze mid-wait, then reset
    bus.mem_vis_status = MEM_BUSY;
    @(negedge clk);
    chk("frz_req", 64'(bus.mem_vis_enabled), 64'd1);
    nxt();
    nxt();
    rdy_in = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("frz_fire", 64'(bus.stage_fire), 64'd0);
      chk("frz_strobes", 64'({bus.mem_vis_enabled, bus.pc_update_en,
          bus.pc_redirect_en, bus.inst_fetch_enabled}), 64'd0);
      chk("frz_valid", 64'(bus.stage_valid), 64'h0f);
      chk("frz_cnt", 64'(bus.stall_cycle_cnt), 64'd10);
      nxt();
    end
    rdy_in = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_wait_valid", 64'(bus.stage_valid), 64'd0);
    chk("rst_wait_cnt", 64'(bus.stall_cycle_cnt), 64'd0);
    chk("rst_wait_ife", 64'(bus.inst_fetch_enabled), 64'd0);
    nxt();
    drive(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b1, MEM_DONE);
    @(negedge clk);
    chk("post_rst_valid", 64'(bus.stage_valid[S-1:1]), 64'd0);
    chk("post_rst_cnt", 64'(bus.stall_cycle_cnt), 64'd0);
    chk("post_rst_vis", 64'(bus.mem_vis_enabled), 64'd0);
    nxt();
    nxt();
    nxt();
    @(negedge clk);
    chk("post_rst_req", 64'(bus.mem_vis_enabled), 64'd1);
    nxt();
    // random traffic
    for (int k = 0; k < 3000; k++) begin
      rst    = ($urandom_range(199) == 0);
      rdy_in = ($urandom_range(9) != 0);
      bus.if_inst_valid = ($urandom_range(3) != 0);
      for (int b = 0; b < S; b++) bus.stage_busy[b] = ($urandom_range(9) == 0);
      bus.id_hazard      = ($urandom_range(7) == 0);
      bus.redirect_valid = ($urandom_range(5) == 0);
      bus.mem_req        = 1'($urandom_range(1));
      bus.mem_vis_status = 2'($urandom_range(3));
      nxt();
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
